// File: rtl/ps2_pkg.sv
// Shared constants and FSM state type for the PS/2 mouse controller.
package ps2_pkg;

  // Host-to-device command bytes
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;

  // Device-to-host response bytes
  localparam logic [7:0] RSP_ACK      = 8'hFA;
  localparam logic [7:0] RSP_RESEND   = 8'hFE;
  localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
  localparam logic [7:0] RSP_BAT_ERR  = 8'hFC;
  localparam logic [7:0] DEV_ID_MOUSE = 8'h00;

  // Controller FSM states
  typedef enum logic [2:0] {
    RST_SEND = 3'd0,
    RST_ACK  = 3'd1,
    RST_BAT  = 3'd2,
    RST_ID   = 3'd3,
    EN_SEND  = 3'd4,
    EN_ACK   = 3'd5,
    STREAM   = 3'd6,
    FAIL     = 3'd7
  } ps2_state_e;

endpackage

// File: rtl/ps2_timeout_counter.sv
// Loadable down-counter; expired is high while the count sits at zero.
// The counter stops at zero instead of wrapping.
module ps2_timeout_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             expired
);

  logic [WIDTH-1:0] cnt_q;

  // Load has priority; otherwise count down and hold at zero
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - WIDTH'(1);
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/ps2_mouse_ctrl.sv
// PS/2 mouse controller: runs the reset/enable init sequence with retries,
// then assembles 3-byte stream packets with sync and inter-byte gap checks.
//
// Handshakes: rx_valid is a one-cycle strobe qualifying rx_data (no
// back-pressure). tx_start is a one-cycle request issued only when tx_busy
// is low; tx_done is a one-cycle strobe marking the end of that transfer.
// packet_done is a one-cycle strobe; packet1..3 are valid from that cycle
// and hold until the next strobe.
import ps2_pkg::*;

module ps2_mouse_ctrl #(
  parameter int unsigned RESP_TIMEOUT = 50_000_000,
  parameter int unsigned GAP_TIMEOUT  = 200_000,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       tx_busy,
  input  logic       tx_done,
  output logic [7:0] tx_data,
  output logic       tx_start,
  output logic       packet_done,
  output logic [7:0] packet1,
  output logic [7:0] packet2,
  output logic [7:0] packet3,
  output logic       init_done,
  output logic       init_error
);

  localparam int RW = $clog2(RESP_TIMEOUT + 1);
  localparam int GW = $clog2(GAP_TIMEOUT + 1);
  localparam int CW = $clog2(MAX_RETRY + 1);

  ps2_state_e      state_q, state_d;
  logic [CW-1:0]   retry_q, retry_d, retry_inc;
  logic            sent_q, sent_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_start_q, tx_start_d;
  logic [1:0]      idx_q, idx_d, cur_idx;
  logic [7:0]      b0_q, b0_d, b1_q, b1_d;
  logic [7:0]      p1_q, p1_d, p2_q, p2_d, p3_q, p3_d;
  logic            done_q, done_d;
  logic            resp_load, gap_load, fail_evt;
  logic            resp_expired, gap_expired;

  ps2_timeout_counter #(.WIDTH(RW)) u_resp_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (resp_load),
    .load_val (RW'(RESP_TIMEOUT)),
    .expired  (resp_expired)
  );

  ps2_timeout_counter #(.WIDTH(GW)) u_gap_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (gap_load),
    .load_val (GW'(GAP_TIMEOUT)),
    .expired  (gap_expired)
  );

  assign retry_inc = retry_q + CW'(1);

  // Next-state logic for the init sequence and stream packet assembly
  always_comb begin
    state_d    = state_q;
    retry_d    = retry_q;
    sent_d     = sent_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    idx_d      = idx_q;
    b0_d       = b0_q;
    b1_d       = b1_q;
    p1_d       = p1_q;
    p2_d       = p2_q;
    p3_d       = p3_q;
    done_d     = 1'b0;
    resp_load  = 1'b0;
    gap_load   = 1'b0;
    fail_evt   = 1'b0;
    // A stale partial packet is dropped before the current byte is judged
    cur_idx    = (gap_expired && idx_q != 2'd0) ? 2'd0 : idx_q;

    case (state_q)
      RST_SEND, EN_SEND: begin
        if (!sent_q) begin
          if (!tx_busy) begin
            tx_start_d = 1'b1;
            tx_data_d  = (state_q == RST_SEND) ? CMD_RESET : CMD_ENABLE;
            sent_d     = 1'b1;
          end
        end else if (tx_done) begin
          sent_d    = 1'b0;
          resp_load = 1'b1;
          state_d   = (state_q == RST_SEND) ? RST_ACK : EN_ACK;
        end
      end
      RST_ACK, EN_ACK: begin
        if (rx_valid && rx_data == RSP_ACK) begin
          resp_load = (state_q == RST_ACK);
          state_d   = (state_q == RST_ACK) ? RST_BAT : STREAM;
        end else if ((rx_valid && (rx_data == RSP_RESEND || rx_data == RSP_BAT_ERR))
                     || resp_expired) begin
          fail_evt = 1'b1;
        end
      end
      RST_BAT: begin
        if (rx_valid && rx_data == RSP_BAT_OK) begin
          resp_load = 1'b1;
          state_d   = RST_ID;
        end else if ((rx_valid && (rx_data == RSP_RESEND || rx_data == RSP_BAT_ERR))
                     || resp_expired) begin
          fail_evt = 1'b1;
        end
      end
      RST_ID: begin
        if (rx_valid) begin
          if (rx_data == DEV_ID_MOUSE) state_d = EN_SEND;
          else                         fail_evt = 1'b1;
        end else if (resp_expired) begin
          fail_evt = 1'b1;
        end
      end
      STREAM: begin
        idx_d = cur_idx;
        if (rx_valid) begin
          case (cur_idx)
            2'd0: begin
              if (rx_data[3]) begin
                b0_d     = rx_data;
                idx_d    = 2'd1;
                gap_load = 1'b1;
              end
            end
            2'd1: begin
              b1_d     = rx_data;
              idx_d    = 2'd2;
              gap_load = 1'b1;
            end
            2'd2: begin
              p1_d     = b0_q;
              p2_d     = b1_q;
              p3_d     = rx_data;
              done_d   = 1'b1;
              idx_d    = 2'd0;
              gap_load = 1'b1;
            end
            default: idx_d = 2'd0;
          endcase
        end
      end
      FAIL: begin
        state_d = FAIL;
      end
      default: state_d = RST_SEND;
    endcase

    if (fail_evt) begin
      retry_d = retry_inc;
      sent_d  = 1'b0;
      state_d = (retry_inc == CW'(MAX_RETRY)) ? FAIL : RST_SEND;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RST_SEND;
      retry_q    <= '0;
      sent_q     <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
      idx_q      <= 2'd0;
      b0_q       <= 8'h00;
      b1_q       <= 8'h00;
      p1_q       <= 8'h00;
      p2_q       <= 8'h00;
      p3_q       <= 8'h00;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      retry_q    <= retry_d;
      sent_q     <= sent_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      idx_q      <= idx_d;
      b0_q       <= b0_d;
      b1_q       <= b1_d;
      p1_q       <= p1_d;
      p2_q       <= p2_d;
      p3_q       <= p3_d;
      done_q     <= done_d;
    end
  end

  assign tx_data     = tx_data_q;
  assign tx_start    = tx_start_q;
  assign packet_done = done_q;
  assign packet1     = p1_q;
  assign packet2     = p2_q;
  assign packet3     = p3_q;
  assign init_done   = (state_q == STREAM);
  assign init_error  = (state_q == FAIL);

endmodule

// File: tb/tb_ps2_mouse_ctrl.sv
// Bench for ps2_mouse_ctrl: directed init/stream/reset/retry scenarios,
// a byte-level packet model feeding an expected queue, and a per-cycle
// compare process on the stream outputs.
module tb_ps2_mouse_ctrl;

  localparam int RESP  = 1000;
  localparam int GAP   = 100;
  localparam int RETRY = 3;

  // Clock / reset
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       tx_busy = 1'b0;
  logic       tx_done = 1'b0;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       packet_done;
  logic [7:0] packet1, packet2, packet3;
  logic       init_done, init_error;

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ps2_mouse_ctrl #(
    .RESP_TIMEOUT (RESP),
    .GAP_TIMEOUT  (GAP),
    .MAX_RETRY    (RETRY)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .packet_done (packet_done),
    .packet1     (packet1),
    .packet2     (packet2),
    .packet3     (packet3),
    .init_done   (init_done),
    .init_error  (init_error)
  );

  // Check bookkeeping
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Packet model: 3-byte framing, sync on bit 3, gap discards partials.
  // Each expected entry is {visible_cycle[31:0], p1, p2, p3}.
  logic [55:0] exp_q[$];
  int          m_idx = 0;
  logic [7:0]  m_b0 = 8'h00, m_b1 = 8'h00;
  int unsigned m_last = 0;
  logic [7:0]  m_p1 = 8'h00, m_p2 = 8'h00, m_p3 = 8'h00;
  bit          model_en = 1'b0;
  bit          chk_en = 1'b0;
  int          tx_cnt = 0;
  int          pd_cnt = 0;

  task automatic model_byte(input logic [7:0] b, input int unsigned q);
    if (m_idx != 0 && (q - m_last) > GAP) m_idx = 0;
    if (m_idx == 0) begin
      if (b[3]) begin
        m_b0 = b; m_idx = 1; m_last = q;
      end
    end else if (m_idx == 1) begin
      m_b1 = b; m_idx = 2; m_last = q;
    end else begin
      exp_q.push_back({q[31:0], m_b0, m_b1, b});
      m_idx = 0; m_last = q;
    end
  endtask

  always @(negedge clk) begin
    if (tx_start) tx_cnt++;
    if (packet_done) pd_cnt++;
  end

  // Per-cycle compare of stream outputs against the model
  always @(negedge clk) begin
    logic due;
    if (chk_en) begin
      due = (exp_q.size() > 0) && (exp_q[0][55:24] == cyc);
      check("packet_done", {31'd0, packet_done}, {31'd0, due});
      if (due) begin
        m_p1 = exp_q[0][23:16];
        m_p2 = exp_q[0][15:8];
        m_p3 = exp_q[0][7:0];
        void'(exp_q.pop_front());
      end
      check("packet1", {24'd0, packet1}, {24'd0, m_p1});
      check("packet2", {24'd0, packet2}, {24'd0, m_p2});
      check("packet3", {24'd0, packet3}, {24'd0, m_p3});
      check("tx_start_in_stream", {31'd0, tx_start}, 32'd0);
    end
  end

  // Driver tasks (all start and end on a falling edge)
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    if (model_en) model_byte(b, cyc + 1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_tx(input int budget, output logic [7:0] d);
    int waited;
    waited = 0;
    d = 8'h00;
    @(negedge clk);
    while (!tx_start && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    check("tx_start_seen", {31'd0, tx_start}, 32'd1);
    if (tx_start) d = tx_data;
  endtask

  task automatic xmit;
    tx_busy = 1'b1;
    @(negedge clk);
    check("tx_start_one_cycle", {31'd0, tx_start}, 32'd0);
    repeat (3) @(negedge clk);
    tx_busy = 1'b0;
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_start"},    {31'd0, tx_start},    32'd0);
    check({tag, "_tx_data"},     {24'd0, tx_data},     32'd0);
    check({tag, "_packet_done"}, {31'd0, packet_done}, 32'd0);
    check({tag, "_packet1"},     {24'd0, packet1},     32'd0);
    check({tag, "_packet2"},     {24'd0, packet2},     32'd0);
    check({tag, "_packet3"},     {24'd0, packet3},     32'd0);
    check({tag, "_init_done"},   {31'd0, init_done},   32'd0);
    check({tag, "_init_error"},  {31'd0, init_error},  32'd0);
  endtask

  task automatic clean_replies_after_reset_cmd;
    idle(5);  send_byte(8'hFA);
    idle(3);  send_byte(8'hAA);
    idle(3);  send_byte(8'h00);
  endtask

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog");
  end

  // Main sequence
  initial begin
    logic [7:0]  d;
    int unsigned t0, spacing;

    reset_n = 1'b0;
    idle(3);
    check_reset_outputs("reset");
    reset_n = 1'b1;

    // Clean init: FF -> FA AA 00, F4 -> FA
    wait_tx(100, d);
    check("cmd_reset", {24'd0, d}, 32'hFF);
    xmit();
    clean_replies_after_reset_cmd();
    wait_tx(100, d);
    check("cmd_enable", {24'd0, d}, 32'hF4);
    xmit();
    idle(3);
    send_byte(8'hFA);
    idle(2);
    check("init_done", {31'd0, init_done}, 32'd1);
    check("init_error_clean", {31'd0, init_error}, 32'd0);
    check("tx_count_init", tx_cnt, 32'd2);

    // Stream traffic with the model and per-cycle compare active
    m_idx = 0;
    model_en = 1'b1;
    chk_en = 1'b1;

    send_byte(8'h09); send_byte(8'h05); send_byte(8'hFB);
    idle(3);
    check("decode_p1", {24'd0, packet1}, 32'h09);
    check("decode_p2", {24'd0, packet2}, 32'h05);
    check("decode_p3", {24'd0, packet3}, 32'hFB);

    send_byte(8'h00); send_byte(8'h08); send_byte(8'h01); send_byte(8'h02);
    idle(3);
    check("resync_p1", {24'd0, packet1}, 32'h08);
    check("resync_p2", {24'd0, packet2}, 32'h01);
    check("resync_p3", {24'd0, packet3}, 32'h02);

    send_byte(8'h08); send_byte(8'h10);
    idle(150);
    send_byte(8'h18); send_byte(8'h20); send_byte(8'h30);
    idle(3);
    check("gap_p1", {24'd0, packet1}, 32'h18);
    check("gap_p2", {24'd0, packet2}, 32'h20);
    check("gap_p3", {24'd0, packet3}, 32'h30);
    check("packet_count", pd_cnt, 32'd3);
    check("exp_q_drained", exp_q.size(), 32'd0);
    check("tx_count_stream", tx_cnt, 32'd2);

    chk_en = 1'b0;
    model_en = 1'b0;

    // Reset mid-packet
    send_byte(8'h08); send_byte(8'h11);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midpkt");
    idle(2);
    reset_n = 1'b1;
    wait_tx(100, d);
    check("restart_cmd", {24'd0, d}, 32'hFF);
    t0 = cyc;
    xmit();

    // No replies: two more FF attempts spaced by the response timeout, then FAIL
    for (int k = 0; k < 2; k++) begin
      wait_tx(1500, d);
      check("retry_cmd", {24'd0, d}, 32'hFF);
      spacing = cyc - t0;
      check("retry_spacing_ok", {31'd0, (spacing >= 1000 && spacing <= 1100)}, 32'd1);
      t0 = cyc;
      xmit();
    end
    idle(1200);
    send_byte(8'hFA);
    idle(5);
    check("fail_init_error", {31'd0, init_error}, 32'd1);
    check("fail_init_done", {31'd0, init_done}, 32'd0);
    check("fail_tx_count", tx_cnt, 32'd5);

    // Reset clears the error; a RESEND reply forces a prompt restart
    reset_n = 1'b0;
    idle(2);
    check("reset_clears_error", {31'd0, init_error}, 32'd0);
    reset_n = 1'b1;
    wait_tx(100, d);
    check("resend_first_cmd", {24'd0, d}, 32'hFF);
    xmit();
    idle(3);
    send_byte(8'hFE);
    wait_tx(50, d);
    check("resend_retry_cmd", {24'd0, d}, 32'hFF);
    xmit();
    clean_replies_after_reset_cmd();
    wait_tx(100, d);
    check("resend_enable_cmd", {24'd0, d}, 32'hF4);
    xmit();
    idle(3);
    send_byte(8'hFA);
    idle(2);
    check("resend_init_done", {31'd0, init_done}, 32'd1);
    check("resend_tx_count", tx_cnt, 32'd8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
